branch_predictor: RTL and testbench

- Dynamic direction predictor for the RISC-V core: a table of 2-bit saturating counters, indexed by PC.
- Fetch side: supplies a registered taken/not-taken prediction.
- Execute side: consumes the resolved outcome from the branch comparator, trains the table and flags mispredictions.
- It is the producer/consumer counterpart of the branch-resolution path: it predicts what the comparator later decides, then learns from that decision.

---
 rtl/branch_predictor.sv | 189 ++++++++++++++++++
 tb/tb_branch_predictor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Dynamic branch direction predictor built from a table of 2-bit saturating
//   counters indexed by PC[IDX_BITS+1:2]. After reset the table is swept to
//   CNT_INIT, one entry per cycle; the predictor then runs.
//
//   Fetch side   : pc_valid/pc in, registered pred_valid/pred_taken out
//                  (latency 1).
//   Execute side : res_valid/res_pc/res_taken/res_pred_taken in. Trains the
//                  counter, raises a registered one-cycle mispredict pulse and
//                  keeps wrapping 32-bit branch and mispredict counters.
//   ready        : high once the init sweep has finished.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pc_valid, pc             fetch lookup request
//   pred_valid, pred_taken   registered prediction
//   res_valid, res_pc        resolved conditional branch
//   res_taken                actual outcome from the branch comparator
//   res_pred_taken           prediction that was used for that branch
//   mispredict               registered one-cycle misprediction pulse
//   ready                    predictor operational
//   branch_count             resolved branches since reset
//   mispredict_count         mispredictions since reset
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int         IDX_BITS = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid,
    input  logic [31:0] pc,
    output logic        pred_valid,
    output logic        pred_taken,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic        res_pred_taken,
    output logic        mispredict,
    output logic        ready,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int DEPTH = 1 << IDX_BITS;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IDX_BITS-1:0] ptr;
    logic                run;

    logic [1:0]          cnt_table [DEPTH];

    logic [IDX_BITS-1:0] look_idx;
    logic [IDX_BITS-1:0] res_idx;
    logic [1:0]          cur_cnt;
    logic [1:0]          upd_cnt;
    logic                bypass_hit;
    logic                look_msb;
    logic                wrong;

    logic                tbl_we;
    logic [IDX_BITS-1:0] tbl_waddr;
    logic [1:0]          tbl_wdata;

    // Only the index bits of the PCs feed the table.
    logic                unused_pc_bits;
    assign unused_pc_bits = ^{pc[31:IDX_BITS+2], pc[1:0],
                              res_pc[31:IDX_BITS+2], res_pc[1:0]};

    assign look_idx = pc[IDX_BITS+1:2];
    assign res_idx  = res_pc[IDX_BITS+1:2];
    assign cur_cnt  = cnt_table[res_idx];
    assign wrong    = res_taken ^ res_pred_taken;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state and outputs
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        run        = 1'b0;
        ready      = 1'b0;
        case (state)
            INIT: begin
                // The sweep finishes on the cycle that writes the last entry.
                if (ptr == IDX_BITS'(DEPTH - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                run   = 1'b1;
                ready = 1'b1;
            end
            default: state_next = INIT;
        endcase
    end

    // Sweep pointer: advances only while sweeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (state == INIT) begin
            ptr <= ptr + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Counter training: 2-bit saturating increment / decrement
    // -------------------------------------------------------------------------
    always_comb begin
        upd_cnt = cur_cnt;
        if (res_taken) begin
            if (cur_cnt != 2'b11) upd_cnt = cur_cnt + 2'b01;
        end else begin
            if (cur_cnt != 2'b00) upd_cnt = cur_cnt - 2'b01;
        end
    end

    // Single table write port, shared by the init sweep and training.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = ptr;
        tbl_wdata = CNT_INIT;
        if (!rst) begin
            if (state == INIT) begin
                tbl_we = 1'b1;
            end else if (res_valid) begin
                tbl_we    = 1'b1;
                tbl_waddr = res_idx;
                tbl_wdata = upd_cnt;
            end
        end
    end

    // NOTE: the table has no reset term; the init sweep gives it a defined
    // value, which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            cnt_table[tbl_waddr] <= tbl_wdata;
        end
    end

    // A lookup hitting the entry trained in the same cycle sees the new value.
    assign bypass_hit = run && res_valid && (res_idx == look_idx);
    assign look_msb   = bypass_hit ? upd_cnt[1] : cnt_table[look_idx][1];

    // -------------------------------------------------------------------------
    // Registered outputs and statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid       <= 1'b0;
            pred_taken       <= 1'b0;
            mispredict       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            pred_valid <= run && pc_valid;
            pred_taken <= run && pc_valid && look_msb;
            mispredict <= run && res_valid && wrong;
            if (run && res_valid) begin
                branch_count <= branch_count + 32'd1;
                if (wrong) begin
                    mispredict_count <= mispredict_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Directed bench for branch_predictor. Stimulus pushes the expected
//   prediction / mispredict pulses (with the cycle they are due) into queues;
//   a negedge monitor pops and compares whenever the DUT shows an output.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic        pred_valid;
    logic        pred_taken;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = '0;
    logic        res_taken = 1'b0;
    logic        res_pred_taken = 1'b0;
    logic        mispredict;
    logic        ready;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_predictor #(
        .IDX_BITS (6),
        .CNT_INIT (2'b01)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_valid         (pc_valid),
        .pc               (pc),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_pred_taken   (res_pred_taken),
        .mispredict       (mispredict),
        .ready            (ready),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   due;
        logic taken;
    } pred_exp_t;

    pred_exp_t pred_q[$];
    int        misp_q[$];
    int        exp_branch = 0;
    int        exp_misp   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        pred_exp_t pe;
        int        due;
        if (pred_valid) begin
            if (pred_q.size() == 0) begin
                check("pred_valid_unexpected", pred_valid, 1'b0);
            end else begin
                pe = pred_q.pop_front();
                check("pred_latency", cyc, pe.due);
                check("pred_taken", pred_taken, pe.taken);
            end
        end else begin
            check("pred_taken_idle", pred_taken, 1'b0);
            if (pred_q.size() > 0 && pred_q[0].due <= cyc) begin
                pe = pred_q.pop_front();
                check("pred_valid_missing", pred_valid, 1'b1);
            end
        end
        if (mispredict) begin
            if (misp_q.size() == 0) begin
                check("mispredict_unexpected", mispredict, 1'b0);
            end else begin
                due = misp_q.pop_front();
                check("mispredict_latency", cyc, due);
            end
        end else if (misp_q.size() > 0 && misp_q[0] <= cyc) begin
            due = misp_q.pop_front();
            check("mispredict_missing", mispredict, 1'b1);
        end
    end

    // --------------------------------------------------------------- stimulus
    // One RUN-mode cycle: optional lookup and optional resolution. Called at a
    // negedge; returns at the next negedge with the results visible.
    task automatic cycle_io(input logic lv, input logic [31:0] lpc, input logic exp_taken,
                            input logic rv, input logic [31:0] rpc,
                            input logic rt, input logic rpt);
        pc_valid       = lv;
        pc             = lpc;
        res_valid      = rv;
        res_pc         = rpc;
        res_taken      = rt;
        res_pred_taken = rpt;
        if (lv) pred_q.push_back('{cyc + 1, exp_taken});
        if (rv) begin
            exp_branch++;
            if (rt ^ rpt) begin
                exp_misp++;
                misp_q.push_back(cyc + 1);
            end
        end
        @(negedge clk);
        pc_valid  = 1'b0;
        res_valid = 1'b0;
        check("branch_count", branch_count, exp_branch);
        check("mispredict_count", mispredict_count, exp_misp);
    endtask

    task automatic lookup(input logic [31:0] lpc, input logic exp_taken);
        cycle_io(1'b1, lpc, exp_taken, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic [31:0] rpc, input logic rt, input logic rpt);
        cycle_io(1'b0, 32'h0, 1'b0, 1'b1, rpc, rt, rpt);
    endtask

    // Assert rst for n cycles, then follow the init sweep cycle by cycle,
    // presenting lookups/resolutions that must be ignored.
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        check("rst_ready", ready, 1'b0);
        check("rst_pred_valid", pred_valid, 1'b0);
        check("rst_mispredict", mispredict, 1'b0);
        check("rst_branch_count", branch_count, 32'h0);
        check("rst_mispredict_count", mispredict_count, 32'h0);
        exp_branch = 0;
        exp_misp   = 0;
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            check("init_ready", ready, (i == DEPTH) ? 32'h1 : 32'h0);
            if (i == 9 || i == DEPTH - 1) begin
                pc_valid       = 1'b1;
                pc             = 32'h100;
                res_valid      = 1'b1;
                res_pc         = 32'h100;
                res_taken      = 1'b1;
                res_pred_taken = 1'b0;
            end else begin
                pc_valid  = 1'b0;
                res_valid = 1'b0;
            end
        end
        check("init_branch_count", branch_count, 32'h0);
        check("init_mispredict_count", mispredict_count, 32'h0);
    endtask

    initial begin
        // Power-up reset (3 cycles) and init sweep.
        do_reset(3);

        // Fresh table: entry 0 = 01.
        lookup(32'h100, 1'b0);

        // Training: mispredicted taken branch, 01 -> 10.
        resolve(32'h100, 1'b1, 1'b0);
        lookup(32'h100, 1'b1);

        // Saturation at 0x104 (index 1).
        repeat (5) resolve(32'h104, 1'b1, 1'b1);   // 01 -> 11 (saturated)
        resolve(32'h104, 1'b0, 1'b1);              // 11 -> 10, mispredict
        lookup(32'h104, 1'b1);
        repeat (2) resolve(32'h104, 1'b0, 1'b0);   // 10 -> 00
        lookup(32'h104, 1'b0);
        resolve(32'h104, 1'b0, 1'b0);              // stays 00
        resolve(32'h104, 1'b1, 1'b0);              // 00 -> 01, mispredict
        lookup(32'h104, 1'b0);

        // Aliasing: 0x200 shares index 0 with 0x100.
        repeat (2) resolve(32'h100, 1'b1, 1'b1);   // 10 -> 11
        lookup(32'h200, 1'b1);

        // Bypass: same-cycle lookup and update of index 2 (01 -> 10).
        cycle_io(1'b1, 32'h108, 1'b1, 1'b1, 32'h108, 1'b1, 1'b0);
        // Different index: lookup idx 3 (01), update idx 4 (01 -> 10).
        cycle_io(1'b1, 32'h10C, 1'b0, 1'b1, 32'h110, 1'b1, 1'b1);
        // Bypass on a falling MSB: idx 2 goes 10 -> 01.
        cycle_io(1'b1, 32'h108, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0);
        lookup(32'h110, 1'b1);
        lookup(32'h113, 1'b1);                     // pc[1:0] ignored
        lookup(32'h108, 1'b0);

        // Mid-operation reset: counts clear, table reinitialised.
        @(negedge clk);
        do_reset(1);
        lookup(32'h100, 1'b0);
        lookup(32'h104, 1'b0);
        resolve(32'h100, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        check("pred_queue_drained", pred_q.size(), 32'h0);
        check("misp_queue_drained", misp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
